// File: rtl/johnson_ctrl_pkg.sv
// Shared types for the Johnson-counter sequencer: command opcodes, FSM states, default widths.
// No logic; latency and backpressure are defined by the modules that import it.
package johnson_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STEPS = 2'd1,
    OP_FREE  = 2'd2,
    OP_STOP  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_RUN_STEPS = 2'd2,
    ST_RUN_FREE  = 2'd3
  } state_t;

  function automatic logic is_run(input state_t s);
    return (s == ST_RUN_STEPS) || (s == ST_RUN_FREE);
  endfunction

endpackage

// File: rtl/johnson_seq_ctrl_if.sv
// Command channel into the sequencer: valid/ready handshake carrying opcode, argument, direction and divider.
// The master holds cmd_valid and its payload until it sees cmd_ready high at a rising edge.
import johnson_ctrl_pkg::*;

interface johnson_seq_ctrl_if #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             cmd_dir;
  logic [DIV_W-1:0] div;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_dir, div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_dir, div,
    output cmd_ready
  );
endinterface

// File: rtl/johnson_ctrl_tick.sv
// Reloadable prescaler: registered tick is high in every cycle whose count value is zero while running.
// Latency: first tick reload+1 cycles after start, then every reload+1 cycles; no backpressure.
module johnson_ctrl_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_nxt;
  logic             tick_nxt;

  // tick is registered from the count about to be stored, so it lines up with cnt_q == 0
  always_comb begin
    cnt_nxt  = cnt_q;
    tick_nxt = 1'b0;
    if (start) begin
      cnt_nxt  = reload;
      tick_nxt = (reload == '0);
    end else if (en) begin
      cnt_nxt  = (cnt_q == '0) ? reload : cnt_q - DIV_W'(1);
      tick_nxt = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tick  <= tick_nxt;
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command sequencer issuing load/shift strobes to the Johnson datapath; all outputs registered, responses one cycle after acceptance.
// cmd_ready drops only during the single LOAD cycle; commands other than STOP arriving mid-run are dropped with err.
module johnson_seq_ctrl
  import johnson_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  johnson_seq_ctrl_if.slave cmd,
  output logic             jc_load,
  output logic [WIDTH-1:0] jc_load_val,
  output logic             jc_shift,
  output logic             jc_dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] remaining_q, remaining_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [WIDTH-1:0] load_val_nxt;
  logic             ready_q;
  logic             accept;
  logic             load_nxt, dir_nxt, done_nxt, aborted_nxt, err_nxt;
  logic             tick_start, tick_en;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;

  always_comb begin
    state_nxt     = state_q;
    remaining_nxt = remaining_q;
    div_nxt       = div_q;
    load_val_nxt  = jc_load_val;
    dir_nxt       = jc_dir;
    load_nxt      = 1'b0;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;
    err_nxt       = 1'b0;
    tick_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_LOAD: begin
              state_nxt    = ST_LOAD;
              load_nxt     = 1'b1;
              load_val_nxt = cmd.cmd_arg;
            end
            OP_STEPS: begin
              dir_nxt = cmd.cmd_dir;
              if (cmd.cmd_arg == '0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt     = ST_RUN_STEPS;
                remaining_nxt = cmd.cmd_arg;
                div_nxt       = cmd.div;
                tick_start    = 1'b1;
              end
            end
            OP_FREE: begin
              dir_nxt    = cmd.cmd_dir;
              state_nxt  = ST_RUN_FREE;
              div_nxt    = cmd.div;
              tick_start = 1'b1;
            end
            default: done_nxt = 1'b1;
          endcase
        end
      end

      ST_LOAD: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end

      ST_RUN_STEPS, ST_RUN_FREE: begin
        if (state_q == ST_RUN_STEPS && jc_shift) begin
          remaining_nxt = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        // STOP wins over a coincident final shift, so the run reports as aborted
        if (accept) begin
          if (cmd.cmd_op == OP_STOP) begin
            state_nxt   = ST_IDLE;
            done_nxt    = 1'b1;
            aborted_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tick_en = is_run(state_q) && (state_nxt != ST_IDLE);

  johnson_ctrl_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .start  (tick_start),
    .en     (tick_en),
    .reload (tick_start ? cmd.div : div_q),
    .tick   (jc_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      div_q       <= '0;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      jc_load     <= 1'b0;
      jc_load_val <= '0;
      jc_dir      <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      remaining_q <= remaining_nxt;
      div_q       <= div_nxt;
      ready_q     <= (state_nxt != ST_LOAD);
      busy        <= (state_nxt != ST_IDLE);
      jc_load     <= load_nxt;
      jc_load_val <= load_val_nxt;
      jc_dir      <= dir_nxt;
      done        <= done_nxt;
      aborted     <= aborted_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: a vector table of single commands from IDLE plus hand-written
// sequences for STOP during FREE, a dropped command mid-run, and reset mid-run.
module tb_johnson_seq_ctrl;
  import johnson_ctrl_pkg::*;

  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  johnson_seq_ctrl_if #(.WIDTH(W), .DIV_W(D)) cmd_if ();

  logic         jc_load, jc_shift, jc_dir, busy, done, aborted, err;
  logic [W-1:0] jc_load_val;

  johnson_seq_ctrl #(.WIDTH(W), .DIV_W(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .jc_load     (jc_load),
    .jc_load_val (jc_load_val),
    .jc_shift    (jc_shift),
    .jc_dir      (jc_dir),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .err         (err)
  );

  typedef struct {
    op_t        op;
    logic [7:0] arg;
    logic       dir;
    logic [7:0] div;
    int         done_cyc;
    int         shifts;
  } vec_t;

  vec_t       vecs [9];
  int         checks = 0;
  int         errors = 0;
  string      ctx;
  logic [7:0] exp_val;
  logic       exp_dir;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s cycle %0d: got %0h expected %0h", ctx, name, c, act, exp);
    end
  endtask

  task automatic chk_all(input int c, input logic e_load, input logic e_shift, input logic e_busy,
                         input logic e_ready, input logic e_done, input logic e_abort,
                         input logic e_err, input logic [7:0] e_val, input logic e_dir);
    chk("jc_load",     c, 32'(jc_load),          32'(e_load));
    chk("jc_shift",    c, 32'(jc_shift),         32'(e_shift));
    chk("busy",        c, 32'(busy),             32'(e_busy));
    chk("cmd_ready",   c, 32'(cmd_if.cmd_ready), 32'(e_ready));
    chk("done",        c, 32'(done),             32'(e_done));
    chk("aborted",     c, 32'(aborted),          32'(e_abort));
    chk("err",         c, 32'(err),              32'(e_err));
    chk("jc_load_val", c, 32'(jc_load_val),      32'(e_val));
    chk("jc_dir",      c, 32'(jc_dir),           32'(e_dir));
  endtask

  task automatic drive(input logic v, input op_t op, input logic [7:0] arg, input logic dir,
                       input logic [7:0] dv);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    cmd_if.cmd_dir   = dir;
    cmd_if.div       = dv;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_LOAD,  8'hA5, 1'b0, 8'd0,   2,   0};
    vecs[1] = '{OP_STEPS, 8'd3,  1'b1, 8'd2,   10,  3};
    vecs[2] = '{OP_STEPS, 8'd0,  1'b0, 8'd5,   1,   0};
    vecs[3] = '{OP_STOP,  8'h00, 1'b1, 8'd0,   1,   0};
    vecs[4] = '{OP_STEPS, 8'd1,  1'b1, 8'd0,   2,   1};
    vecs[5] = '{OP_STEPS, 8'd2,  1'b0, 8'd3,   9,   2};
    vecs[6] = '{OP_LOAD,  8'h3C, 1'b1, 8'd9,   2,   0};
    vecs[7] = '{OP_STEPS, 8'd255, 1'b1, 8'd0,  256, 255};
    vecs[8] = '{OP_STEPS, 8'd1,  1'b0, 8'd255, 257, 1};

    drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ctx = "reset";
    chk_all(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    rst = 1'b0;
    exp_val = 8'h00;
    exp_dir = 1'b0;

    for (int i = 0; i < 9; i++) begin
      vec_t v;
      int   nshift;
      int   p;
      v = vecs[i];
      p = int'(v.div) + 1;
      nshift = 0;
      ctx = $sformatf("vec%0d", i);
      drive(1'b1, v.op, v.arg, v.dir, v.div);
      if (v.op == OP_LOAD) exp_val = v.arg;
      if (v.op == OP_STEPS || v.op == OP_FREE) exp_dir = v.dir;
      for (int c = 1; c <= v.done_cyc + 1; c++) begin
        logic e_shift, e_busy;
        @(negedge clk);
        if (c == 1) drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
        e_shift = (v.op == OP_STEPS) && (v.arg != 0) && (c % p == 0) && (c / p <= int'(v.arg));
        e_busy  = (v.op == OP_LOAD) ? (c == 1) :
                  ((v.op == OP_STEPS) && (v.arg != 0) && (c < v.done_cyc));
        chk_all(c, (v.op == OP_LOAD) && (c == 1), e_shift, e_busy,
                !((v.op == OP_LOAD) && (c == 1)), c == v.done_cyc, 0, 0, exp_val, exp_dir);
        nshift += int'(jc_shift);
      end
      chk("shift_count", 0, 32'(nshift), 32'(v.shifts));
    end

    // FREE at div=0, STOP accepted at the end of cycle 5
    ctx = "free_stop";
    drive(1'b1, OP_FREE, 8'h00, 1'b1, 8'd0);
    exp_dir = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5)      chk_all(c, 0, 1, 1, 1, 0, 0, 0, exp_val, exp_dir);
      else if (c == 6) chk_all(c, 0, 0, 0, 1, 1, 1, 0, exp_val, exp_dir);
      else             chk_all(c, 0, 0, 0, 1, 0, 0, 0, exp_val, exp_dir);
      if (c == 5) drive(1'b1, OP_STOP, 8'h00, 1'b0, 8'd0);
      else        drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
    end

    // LOAD arriving mid-STEPS is dropped with err; run timing unchanged
    ctx = "load_in_run";
    drive(1'b1, OP_STEPS, 8'd3, 1'b0, 8'd2);
    exp_dir = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk_all(c, 0, (c == 3) || (c == 6) || (c == 9), c < 10, 1, c == 10, 0, c == 5,
              exp_val, exp_dir);
      if (c == 4) drive(1'b1, OP_LOAD, 8'h11, 1'b1, 8'd7);
      else        drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
    end

    // reset in the middle of a STEPS run
    ctx = "reset_mid_run";
    drive(1'b1, OP_STEPS, 8'd5, 1'b1, 8'd1);
    exp_dir = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
      if (c <= 3) begin
        chk_all(c, 0, c == 2, 1, 1, 0, 0, 0, exp_val, exp_dir);
        if (c == 3) rst = 1'b1;
      end else begin
        if (c == 4) begin
          rst = 1'b0;
          exp_val = 8'h00;
          exp_dir = 1'b0;
        end
        chk_all(c, 0, 0, 0, 1, 0, 0, 0, exp_val, exp_dir);
      end
    end

    ctx = "load_after_reset";
    drive(1'b1, OP_LOAD, 8'h5A, 1'b0, 8'd0);
    exp_val = 8'h5A;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, OP_LOAD, 8'h00, 1'b0, 8'd0);
      chk_all(c, c == 1, 0, c == 1, c != 1, c == 2, 0, 0, exp_val, exp_dir);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
